// File: rtl/a51_keystream_xor.sv
// Serial XOR of the A5/1 output-stage keystream into a captured message, MSB first,
// with byte-wise readout. Define A51_KS_CAPTURE_EN to also record the raw keystream.
module a51_keystream_xor #(
  parameter int MSG_BITS = 224,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MSG_BITS-1:0] data_in,
  input  logic                ks_bit,
  input  logic                ks_valid,
  output logic                busy,
  output logic                done,
  output logic [MSG_BITS-1:0] result,
  output logic [CNT_W-1:0]    bit_count,
  input  logic [4:0]          byte_index,
  output logic [7:0]          byte_out
`ifdef A51_KS_CAPTURE_EN
  ,
  output logic [MSG_BITS-1:0] ks_capture
`endif
);

  localparam int NBYTES = MSG_BITS / 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HOLD} state_t;

  state_t              state, state_n;
  logic [MSG_BITS-1:0] msg;
  logic [CNT_W-1:0]    wr_idx;
  logic                load, consume, last;

  // Load beats a coincident keystream bit because consume is gated on RUN.
  assign load    = start && (state == S_IDLE || state == S_HOLD);
  assign consume = ks_valid && (state == S_RUN);
  assign last    = (bit_count == LAST_BIT);
  assign wr_idx  = LAST_BIT - bit_count;

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (consume && last) state_n = S_DONE;
      S_DONE:  state_n = S_HOLD;
      S_HOLD:  if (start) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg       <= '0;
      result    <= '0;
      bit_count <= '0;
    end else if (load) begin
      msg       <= data_in;
      result    <= '0;
      bit_count <= '0;
    end else if (consume) begin
      result[wr_idx] <= msg[wr_idx] ^ ks_bit;
      bit_count      <= bit_count + CNT_W'(1);
    end
  end

`ifdef A51_KS_CAPTURE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ks_capture         <= '0;
    else if (load)    ks_capture         <= '0;
    else if (consume) ks_capture[wr_idx] <= ks_bit;
  end
`endif

  // Byte 0 is the most significant byte of the result.
  logic [NBYTES-1:0][7:0] res_bytes;
  for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
    assign res_bytes[g] = result[MSG_BITS-1-8*g -: 8];
  end

  always_comb begin
    byte_out = '0;
    for (int i = 0; i < NBYTES; i++)
      if (byte_index == 5'(i)) byte_out = res_bytes[i];
  end

endmodule

// File: tb/tb_a51_keystream_xor.sv
// Scoreboard bench for a51_keystream_xor: expected results are queued at stimulus
// time and compared when the pass signals done.
module tb_a51_keystream_xor;

  localparam int MSG_BITS = 224;
  localparam int CNT_W    = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [MSG_BITS-1:0] data_in;
  logic                ks_bit;
  logic                ks_valid;
  logic                busy;
  logic                done;
  logic [MSG_BITS-1:0] result;
  logic [CNT_W-1:0]    bit_count;
  logic [4:0]          byte_index;
  logic [7:0]          byte_out;
`ifdef A51_KS_CAPTURE_EN
  logic [MSG_BITS-1:0] ks_capture;
`endif

  a51_keystream_xor #(.MSG_BITS(MSG_BITS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .ks_bit     (ks_bit),
    .ks_valid   (ks_valid),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .bit_count  (bit_count),
    .byte_index (byte_index),
    .byte_out   (byte_out)
`ifdef A51_KS_CAPTURE_EN
    ,
    .ks_capture (ks_capture)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [MSG_BITS-1:0] sb_q[$];

  // Starts a pass and feeds ks[223] first. Inputs change on negedge, outputs are
  // sampled there too. RUN cycle 0 is the first cycle after the start edge.
  task automatic drive_pass(input logic [MSG_BITS-1:0] data, input logic [MSG_BITS-1:0] ks,
                            input bit gapped, input int start_at,
                            output int done_cyc, output int done_cnt);
    int i;
    @(negedge clk);
    start = 1'b1; data_in = data; ks_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    i = 0; done_cyc = -1; done_cnt = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      start = 1'b0;
      if (i < MSG_BITS && (!gapped || (cyc % 2) == 0)) begin
        if (i == start_at) begin start = 1'b1; data_in = ~data; end
        ks_valid = 1'b1; ks_bit = ks[MSG_BITS-1-i]; i++;
      end else begin
        ks_valid = 1'b0; ks_bit = 1'($urandom_range(1));
      end
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
      @(negedge clk);
    end
    ks_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; data_in = '0; ks_bit = 1'b0; ks_valid = 1'b0; byte_index = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
    checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    int dc, dn;
    logic [MSG_BITS-1:0] exp, held;
    sb_q.push_back({MSG_BITS{1'b1}});
    drive_pass('0, {MSG_BITS{1'b1}}, 1'b0, -1, dc, dn);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL ones_timeout: done never seen"); void'(sb_q.pop_front()); return; end
    exp = sb_q.pop_front();
    checks++; if (result !== exp) begin failures++; $display("FAIL ones_result: got %h expected %h", result, exp); end
    checks++; if (dc !== 224) begin failures++; $display("FAIL ones_done_cycle: got %0d expected 224", dc); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL ones_done_pulses: got %0d expected 1", dn); end
    checks++; if (bit_count !== 8'd224) begin failures++; $display("FAIL ones_bit_count: got %0d expected 224", bit_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ones_busy_hold: got %b expected 0", busy); end
    byte_index = 5'd0; #1;
    checks++; if (byte_out !== 8'hFF) begin failures++; $display("FAIL ones_byte0: got %h expected ff", byte_out); end
    // HOLD must ignore further keystream bits
    held = result;
    ks_valid = 1'b1; ks_bit = 1'b0;
    repeat (5) @(negedge clk);
    ks_valid = 1'b0;
    checks++; if (result !== held) begin failures++; $display("FAIL hold_result: got %h expected %h", result, held); end
    checks++; if (bit_count !== 8'd224) begin failures++; $display("FAIL hold_bit_count: got %0d expected 224", bit_count); end
  endtask

  task automatic test_gapped();
    int dc, dn;
    logic [MSG_BITS-1:0] d, k, exp;
    d = {28{8'hA5}};
    k = {112{2'b10}};
    sb_q.push_back(d ^ k);
    drive_pass(d, k, 1'b1, -1, dc, dn);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL gap_timeout: done never seen"); void'(sb_q.pop_front()); return; end
    exp = sb_q.pop_front();
    checks++; if (result !== exp) begin failures++; $display("FAIL gap_result: got %h expected %h", result, exp); end
    // 224 valid cycles interleaved with 223 idle cycles
    checks++; if (dc !== 447) begin failures++; $display("FAIL gap_done_cycle: got %0d expected 447", dc); end
    checks++; if (bit_count !== 8'd224) begin failures++; $display("FAIL gap_bit_count: got %0d expected 224", bit_count); end
  endtask

  task automatic test_round_trip();
    int dc, dn;
    logic [MSG_BITS-1:0] m, k, exp, ct;
    m = {64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 32'h89ABCDEF};
    k = {32'h9E3779B9, 32'h7F4A7C15, 32'hF39CC060, 32'h5CEDC834, 32'h1082276B, 32'hF3A27251, 32'hF86C6A11};
    sb_q.push_back(m ^ k);
    drive_pass(m, k, 1'b0, -1, dc, dn);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL rt_enc_timeout: done never seen"); void'(sb_q.pop_front()); return; end
    exp = sb_q.pop_front();
    checks++; if (result !== exp) begin failures++; $display("FAIL rt_encrypt: got %h expected %h", result, exp); end
    ct = result;
    sb_q.push_back(m);
    drive_pass(ct, k, 1'b0, -1, dc, dn);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL rt_dec_timeout: done never seen"); void'(sb_q.pop_front()); return; end
    exp = sb_q.pop_front();
    checks++; if (result !== exp) begin failures++; $display("FAIL rt_decrypt: got %h expected %h", result, exp); end
  endtask

  task automatic test_start_priority();
    // From HOLD: start and a valid bit together -> load only, bit dropped
    @(negedge clk);
    start = 1'b1; data_in = {MSG_BITS{1'b1}}; ks_valid = 1'b1; ks_bit = 1'b1;
    @(negedge clk);
    start = 1'b0; ks_valid = 1'b0;
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL prio_bit_count: got %0d expected 0", bit_count); end
    checks++; if (result !== '0) begin failures++; $display("FAIL prio_result: got %h expected 0", result); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_busy: got %b expected 1", busy); end
    // Unprocessed bits read 0 after one consumed bit
    ks_valid = 1'b1; ks_bit = 1'b0;
    @(negedge clk);
    ks_valid = 1'b0;
    checks++; if (result !== {1'b1, {(MSG_BITS-1){1'b0}}}) begin failures++; $display("FAIL prio_first_bit: got %h expected msb only", result); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_abort();
    int dc, dn;
    logic [MSG_BITS-1:0] d, k, exp;
    d = {7{32'h13579BDF}};
    k = {7{32'hC0FFEE11}};
    @(negedge clk);
    start = 1'b1; data_in = d;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ks_valid = 1'b1; ks_bit = k[MSG_BITS-1-i];
      @(negedge clk);
    end
    ks_valid = 1'b0;
    checks++; if (bit_count !== 8'd100) begin failures++; $display("FAIL abort_pre_count: got %0d expected 100", bit_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (result !== '0) begin failures++; $display("FAIL abort_result: got %h expected 0", result); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL abort_bit_count: got %0d expected 0", bit_count); end
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(d ^ k);
    drive_pass(d, k, 1'b0, -1, dc, dn);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL abort_timeout: done never seen"); void'(sb_q.pop_front()); return; end
    exp = sb_q.pop_front();
    checks++; if (result !== exp) begin failures++; $display("FAIL abort_rerun: got %h expected %h", result, exp); end
  endtask

  task automatic test_start_ignored_readout();
    int dc, dn;
    logic [MSG_BITS-1:0] d, k, exp;
    d = {7{32'h2468ACE0}};
    k = {7{32'h0F1E2D3C}};
    sb_q.push_back(d ^ k);
    drive_pass(d, k, 1'b0, 50, dc, dn);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL ign_timeout: done never seen"); void'(sb_q.pop_front()); return; end
    exp = sb_q.pop_front();
    checks++; if (result !== exp) begin failures++; $display("FAIL ign_result: got %h expected %h", result, exp); end
    checks++; if (dc !== 224) begin failures++; $display("FAIL ign_done_cycle: got %0d expected 224", dc); end
    byte_index = 5'd28; #1;
    checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL rd_idx28: got %h expected 00", byte_out); end
    byte_index = 5'd31; #1;
    checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL rd_idx31: got %h expected 00", byte_out); end
    byte_index = 5'd27; #1;
    checks++; if (byte_out !== exp[7:0]) begin failures++; $display("FAIL rd_idx27: got %h expected %h", byte_out, exp[7:0]); end
    byte_index = 5'd0; #1;
    checks++; if (byte_out !== exp[223:216]) begin failures++; $display("FAIL rd_idx0: got %h expected %h", byte_out, exp[223:216]); end
    byte_index = 5'd13; #1;
    checks++; if (byte_out !== exp[119:112]) begin failures++; $display("FAIL rd_idx13: got %h expected %h", byte_out, exp[119:112]); end
  endtask

`ifdef A51_KS_CAPTURE_EN
  task automatic test_capture();
    int dc, dn;
    logic [MSG_BITS-1:0] d, k, exp;
    d = {7{32'h55AA33CC}};
    k = {7{32'hDEADBEEF}};
    sb_q.push_back(k);
    drive_pass(d, k, 1'b1, -1, dc, dn);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL cap_timeout: done never seen"); void'(sb_q.pop_front()); return; end
    exp = sb_q.pop_front();
    checks++; if (ks_capture !== exp) begin failures++; $display("FAIL cap_pattern: got %h expected %h", ks_capture, exp); end
    checks++; if (result !== (d ^ k)) begin failures++; $display("FAIL cap_result: got %h expected %h", result, d ^ k); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_ones();
    test_gapped();
    test_round_trip();
    test_start_priority();
    test_reset_abort();
    test_start_ignored_readout();
`ifdef A51_KS_CAPTURE_EN
    test_capture();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
